// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table and FSM state type for the iterative CORDIC engine.
package cordic_pkg;

  // Angles are S2.13 radians; the table and constants below assume a 16-bit angle word.
  localparam int unsigned ANG_W = 16;
  localparam int unsigned IDX_W = 4;

  localparam logic signed [ANG_W-1:0] PI      = 16'sd25736;
  localparam logic signed [ANG_W-1:0] HALF_PI = 16'sd12868;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Rounded atan(2^-i) in S2.13 for i = 0..13.
  function automatic logic signed [ANG_W-1:0] atan_lut(input logic [IDX_W-1:0] idx);
    logic signed [ANG_W-1:0] v;
    case (idx)
      4'd0:    v = 16'sd6434;
      4'd1:    v = 16'sd3798;
      4'd2:    v = 16'sd2007;
      4'd3:    v = 16'sd1019;
      4'd4:    v = 16'sd511;
      4'd5:    v = 16'sd256;
      4'd6:    v = 16'sd128;
      4'd7:    v = 16'sd64;
      4'd8:    v = 16'sd32;
      4'd9:    v = 16'sd16;
      4'd10:   v = 16'sd8;
      4'd11:   v = 16'sd4;
      4'd12:   v = 16'sd2;
      4'd13:   v = 16'sd1;
      default: v = 16'sd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_iter_engine_if.sv
// Request/response bundle between a CORDIC client and the iterative engine.
interface cordic_iter_engine_if #(
  parameter int unsigned W  = 14,
  parameter int unsigned AW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 mode;
  logic signed [W-1:0]  x_in;
  logic signed [W-1:0]  y_in;
  logic signed [AW-1:0] z_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [W+1:0]  x_out;
  logic signed [W+1:0]  y_out;
  logic signed [AW-1:0] z_out;

  modport master (
    output in_valid, mode, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out
  );

  modport slave (
    input  in_valid, mode, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out
  );
endinterface

// File: rtl/cordic_micro_rot.sv
// One CORDIC micro-rotation; the shift index selects both the shift and the table angle.
module cordic_micro_rot
  import cordic_pkg::*;
#(
  parameter int unsigned XW = 16,
  parameter int unsigned AW = 16
) (
  input  logic                 mode,
  input  logic [IDX_W-1:0]     shift,
  input  logic signed [XW-1:0] x_cur,
  input  logic signed [XW-1:0] y_cur,
  input  logic signed [AW-1:0] z_cur,
  output logic signed [XW-1:0] x_next,
  output logic signed [XW-1:0] y_next,
  output logic signed [AW-1:0] z_next
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;
  logic signed [AW-1:0] ang;
  logic                 d_pos;

  // Direction: rotation chases Z to zero, vectoring chases Y to zero.
  always_comb begin
    x_sh  = x_cur >>> shift;
    y_sh  = y_cur >>> shift;
    ang   = AW'(atan_lut(shift));
    d_pos = mode ? ~z_cur[AW-1] : y_cur[XW-1];
    if (d_pos) begin
      x_next = x_cur - y_sh;
      y_next = y_cur + x_sh;
      z_next = z_cur - ang;
    end else begin
      x_next = x_cur + y_sh;
      y_next = y_cur - x_sh;
      z_next = z_cur + ang;
    end
  end

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, vectoring or rotation mode.
module cordic_iter_engine
  import cordic_pkg::*;
#(
  parameter int unsigned W      = 14,
  parameter int unsigned AW     = 16,
  parameter int unsigned N_ITER = 12
) (
  input logic                 clk,
  input logic                 rst,
  cordic_iter_engine_if.slave bus
);

  localparam int unsigned       XW   = W + 2;
  localparam logic [IDX_W-1:0]  LAST = IDX_W'(N_ITER - 1);

  state_t               state, state_d;
  logic [IDX_W-1:0]     iter, iter_d;
  logic                 mode_r, mode_d;
  logic signed [XW-1:0] x_r, x_d, y_r, y_d;
  logic signed [AW-1:0] z_r, z_d;
  logic signed [XW-1:0] x_out_d, y_out_d;
  logic signed [AW-1:0] z_out_d;
  logic                 in_ready_d, out_valid_d;

  logic signed [XW-1:0] x_ext, y_ext, pre_x, pre_y;
  logic signed [AW-1:0] pre_z;
  logic signed [XW-1:0] x_nx, y_nx;
  logic signed [AW-1:0] z_nx;

  // Quadrant fold into the CORDIC convergence range; W+2 bits keep negation safe.
  always_comb begin
    x_ext = XW'(bus.x_in);
    y_ext = XW'(bus.y_in);
    pre_x = x_ext;
    pre_y = y_ext;
    pre_z = bus.z_in;
    if (!bus.mode) begin
      if (bus.x_in[W-1]) begin
        pre_x = -x_ext;
        pre_y = -y_ext;
        pre_z = bus.y_in[W-1] ? bus.z_in - AW'(PI) : bus.z_in + AW'(PI);
      end
    end else if (bus.z_in > AW'(HALF_PI)) begin
      pre_x = -x_ext;
      pre_y = -y_ext;
      pre_z = bus.z_in - AW'(PI);
    end else if (bus.z_in < -AW'(HALF_PI)) begin
      pre_x = -x_ext;
      pre_y = -y_ext;
      pre_z = bus.z_in + AW'(PI);
    end
  end

  cordic_micro_rot #(.XW(XW), .AW(AW)) u_rot (
    .mode   (mode_r),
    .shift  (iter),
    .x_cur  (x_r),
    .y_cur  (y_r),
    .z_cur  (z_r),
    .x_next (x_nx),
    .y_next (y_nx),
    .z_next (z_nx)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d     = state;
    iter_d      = iter;
    mode_d      = mode_r;
    x_d         = x_r;
    y_d         = y_r;
    z_d         = z_r;
    x_out_d     = bus.x_out;
    y_out_d     = bus.y_out;
    z_out_d     = bus.z_out;
    in_ready_d  = 1'b0;
    out_valid_d = bus.out_valid;
    case (state)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && bus.in_ready) begin
          mode_d     = bus.mode;
          x_d        = pre_x;
          y_d        = pre_y;
          z_d        = pre_z;
          iter_d     = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        x_d    = x_nx;
        y_d    = y_nx;
        z_d    = z_nx;
        iter_d = iter + IDX_W'(1);
        if (iter == LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.out_valid) begin
          out_valid_d = 1'b1;
          x_out_d     = x_r;
          y_out_d     = y_r;
          z_out_d     = z_r;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      iter          <= '0;
      mode_r        <= 1'b0;
      x_r           <= '0;
      y_r           <= '0;
      z_r           <= '0;
      bus.x_out     <= '0;
      bus.y_out     <= '0;
      bus.z_out     <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      state         <= state_d;
      iter          <= iter_d;
      mode_r        <= mode_d;
      x_r           <= x_d;
      y_r           <= y_d;
      z_r           <= z_d;
      bus.x_out     <= x_out_d;
      bus.y_out     <= y_out_d;
      bus.z_out     <= z_out_d;
      bus.in_ready  <= in_ready_d;
      bus.out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Randomized self-checking bench for cordic_iter_engine against an integer CORDIC model.
module tb_cordic_iter_engine;

  localparam int W      = 14;
  localparam int AW     = 16;
  localparam int N_ITER = 12;
  localparam int XW     = W + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cordic_iter_engine_if #(.W(W), .AW(AW)) bus ();

  cordic_iter_engine #(.W(W), .AW(AW), .N_ITER(N_ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int atan_tab[0:15];
  int pi_q;
  int half_pi_q;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int wrap(input int v, input int n);
    int t;
    t = v <<< (32 - n);
    return t >>> (32 - n);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: quadrant fold then N_ITER shift-add steps, all in plain integers.
  task automatic model(input bit md, input int xi, input int yi, input int zi,
                       output int ex, output int ey, output int ez);
    int x, y, z, xn, yn;
    bit dp;
    x = xi; y = yi; z = zi;
    if (!md) begin
      if (xi < 0) begin
        x = -xi; y = -yi;
        z = (yi >= 0) ? zi + pi_q : zi - pi_q;
      end
    end else if (zi > half_pi_q) begin
      x = -xi; y = -yi; z = zi - pi_q;
    end else if (zi < -half_pi_q) begin
      x = -xi; y = -yi; z = zi + pi_q;
    end
    z = wrap(z, AW);
    for (int i = 0; i < N_ITER; i++) begin
      dp = md ? (z >= 0) : (y < 0);
      if (dp) begin
        xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_tab[i];
      end else begin
        xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_tab[i];
      end
      x = wrap(xn, XW); y = wrap(yn, XW); z = wrap(z, AW);
    end
    ex = x; ey = y; ez = z;
  endtask

  task automatic run_op(input bit md, input int x, input int y, input int z,
                        input int stall, input string tag,
                        output int rx, output int ry, output int rz);
    int ex, ey, ez, n;
    bit got;
    model(md, x, y, z, ex, ey, ez);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_eq({tag, "_in_ready"}, int'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.mode      = md;
    bus.x_in      = W'(x);
    bus.y_in      = W'(y);
    bus.z_in      = AW'(z);
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    // Garbage with in_valid high while busy must be ignored.
    bus.x_in = W'($urandom);
    bus.y_in = W'($urandom);
    bus.z_in = AW'($urandom);
    bus.mode = 1'($urandom);
    check_eq({tag, "_busy_ready"}, int'(bus.in_ready), 0);
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1; n++;
      if (n == 5) bus.in_valid = 1'b0;
      got = bus.out_valid;
    end
    bus.in_valid = 1'b0;
    check_eq({tag, "_latency"}, n, N_ITER + 1);
    check_eq({tag, "_x"}, int'(bus.x_out), ex);
    check_eq({tag, "_y"}, int'(bus.y_out), ey);
    check_eq({tag, "_z"}, int'(bus.z_out), ez);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold_valid"}, int'(bus.out_valid), 1);
      check_eq({tag, "_hold_x"}, int'(bus.x_out), ex);
      check_eq({tag, "_hold_y"}, int'(bus.y_out), ey);
      check_eq({tag, "_hold_z"}, int'(bus.z_out), ez);
      check_eq({tag, "_hold_ready"}, int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_drop_valid"}, int'(bus.out_valid), 0);
    check_eq({tag, "_back_ready"}, int'(bus.in_ready), 1);
    rx = int'(bus.x_out); ry = int'(bus.y_out); rz = int'(bus.z_out);
  endtask

  initial begin
    int rx, ry, rz, x, y, z, st, seen;
    bit md;
    for (int i = 0; i < 16; i++)
      atan_tab[i] = $rtoi($atan(2.0 ** (-i)) * (2.0 ** (AW - 3)) + 0.5);
    pi_q      = $rtoi(3.14159265358979 * (2.0 ** (AW - 3)) + 0.5);
    half_pi_q = $rtoi(1.57079632679490 * (2.0 ** (AW - 3)) + 0.5);

    bus.in_valid = 1'b0; bus.mode = 1'b0; bus.out_ready = 1'b0;
    bus.x_in = '0; bus.y_in = '0; bus.z_in = '0;

    // Reset state
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", int'(bus.out_valid), 0);
    check_eq("rst_in_ready", int'(bus.in_ready), 0);
    check_eq("rst_x_out", int'(bus.x_out), 0);
    check_eq("rst_z_out", int'(bus.z_out), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("post_rst_in_ready", int'(bus.in_ready), 1);

    // Directed vectors with ballpark expectations from real-valued CORDIC
    run_op(1'b0, 2048, 0, 0, 0, "vec_x", rx, ry, rz);
    check_eq("vec_x_tol_x", int'(iabs(rx - 3373) <= N_ITER), 1);
    check_eq("vec_x_tol_y", int'(iabs(ry) <= N_ITER), 1);
    check_eq("vec_x_tol_z", int'(iabs(rz) <= N_ITER), 1);
    run_op(1'b0, 2048, 2048, 0, 0, "vec_45", rx, ry, rz);
    check_eq("vec_45_tol_x", int'(iabs(rx - 4770) <= N_ITER), 1);
    check_eq("vec_45_tol_z", int'(iabs(rz - 6434) <= N_ITER), 1);
    run_op(1'b0, -2048, 2048, 0, 0, "vec_135", rx, ry, rz);
    check_eq("vec_135_tol_z", int'(iabs(rz - 19302) <= N_ITER), 1);
    check_eq("vec_135_tol_y", int'(iabs(ry) <= N_ITER), 1);
    run_op(1'b1, 2048, 0, 6434, 0, "rot_45", rx, ry, rz);
    check_eq("rot_45_tol_x", int'(iabs(rx - 2385) <= N_ITER), 1);
    check_eq("rot_45_tol_y", int'(iabs(ry - 2385) <= N_ITER), 1);
    check_eq("rot_45_tol_z", int'(iabs(rz) <= N_ITER), 1);
    run_op(1'b1, 2048, 0, 19302, 0, "rot_135", rx, ry, rz);
    check_eq("rot_135_tol_x", int'(iabs(rx + 2385) <= N_ITER), 1);
    check_eq("rot_135_tol_y", int'(iabs(ry - 2385) <= N_ITER), 1);

    // Most-negative operands and backpressure
    run_op(1'b0, -8192, -8192, 0, 5, "vec_minneg", rx, ry, rz);
    run_op(1'b1, -8192, 8191, -25000, 0, "rot_minneg", rx, ry, rz);

    // Reset in the middle of an operation
    bus.in_valid = 1'b1; bus.mode = 1'b0;
    bus.x_in = W'(3000); bus.y_in = W'(-1000); bus.z_in = '0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_out_valid", int'(bus.out_valid), 0);
    check_eq("abort_x_out", int'(bus.x_out), 0);
    check_eq("abort_y_out", int'(bus.y_out), 0);
    check_eq("abort_z_out", int'(bus.z_out), 0);
    check_eq("abort_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check_eq("abort_no_result", seen, 0);
    run_op(1'b0, 1500, -700, 1000, 0, "after_abort", rx, ry, rz);

    // Randomized operations
    for (int t = 0; t < 40; t++) begin
      md = 1'($urandom);
      x  = int'($urandom_range(0, 16383)) - 8192;
      y  = int'($urandom_range(0, 16383)) - 8192;
      z  = wrap(int'($urandom), AW);
      st = int'($urandom_range(0, 2));
      run_op(md, x, y, z, st, $sformatf("rnd%0d", t), rx, ry, rz);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cordic_iter_engine.md
CORDIC_ITER_ENGINE -- requirements
Module: cordic_iter_engine

Interface
REQ-001 Parameter W, 14: x/y input width, signed S1.(W-2).
REQ-002 Parameter AW, 16: angle width, signed S2.(AW-3) radians, range +/-pi.
REQ-003 Parameter N_ITER, 12: micro-rotations per operation, 1..AW-2.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  request present; in_ready  out  1  engine can accept.
REQ-007 mode  in  1  0 = vectoring (drive Y to 0), 1 = rotation (drive Z to 0).
REQ-008 x_in, y_in  in  W  signed operands; z_in  in  AW  signed initial angle.
REQ-009 out_valid  in/out  1 (out)  result present; out_ready  in  1  consumer accepts.
REQ-010 x_out, y_out  out  W+2  signed S3.(W-2), CORDIC gain (~1.6468) not compensated; z_out  out  AW.

Function
REQ-011 FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-012 IDLE: on in_valid&in_ready, register mode and sign-extended operands (W+2 internal), apply REQ-016/017 pre-rotation, clear iter counter, go RUN.
REQ-013 RUN: each cycle apply micro-rotation i = iter, iter++; after i = N_ITER-1 go DONE.
REQ-014 Micro-rotation: d = +1 if (vectoring ? Y<0 : Z>=0), else -1; X' = X - d*(Y>>>i), Y' = Y + d*(X>>>i), Z' = Z - d*ATAN[i]; arithmetic shift, truncation, no rounding.
REQ-015 out_valid rises exactly N_ITER+1 rising edges after the accepting edge; x/y/z_out registered, stable while out_valid&!out_ready.
REQ-016 Vectoring pre-rotation: if x_in<0, negate X and Y, Z = z_in + pi if y_in>=0 else z_in - pi; else unchanged.
REQ-017 Rotation pre-rotation: if z_in > pi/2, negate X,Y, Z = z_in - pi; if z_in < -pi/2, negate X,Y, Z = z_in + pi.
REQ-018 DONE: hold outputs until out_valid&out_ready, then IDLE; in_ready returns 1 the following cycle (no same-cycle accept).
REQ-019 in_valid ignored outside IDLE; inputs need be stable only on the accepting edge.
REQ-020 Negation of most-negative W-bit input shall not overflow (W+2 internal width).
REQ-021 Z arithmetic in AW bits, two's-complement wrap; no saturation anywhere.

Reset
REQ-022 rst asserted: state IDLE, iter 0, out_valid 0, x_out/y_out/z_out 0, in_ready 1 after rst deasserts (0 while asserted).
REQ-023 rst mid-RUN or mid-DONE aborts the operation; no result emitted for it.

Structure
REQ-024 Package cordic_pkg: ATAN table (atan(2^-i), S2.(AW-3), rounded, i=0..AW-3), PI and HALF_PI constants, FSM state enum.
REQ-025 One sub-module cordic_micro_rot (combinational, shift index as input) performing REQ-014; engine instantiates it once, iterating over time.

Verification (W=14, AW=16, N_ITER=12; tolerance +/-N_ITER LSB)
REQ-026 Vectoring x=2048, y=0, z=0 -> after 13 edges out_valid; x_out~3373, y_out~0, z_out~0.
REQ-027 Vectoring x=2048, y=2048, z=0 -> x_out~4770, y_out~0, z_out~6434 (pi/4); x=-2048, y=2048 -> z_out~19302 (3pi/4).
REQ-028 Rotation x=2048, y=0, z=6434 -> x_out~2385, y_out~2385, z_out~0; z=19302 -> x_out~-2385, y_out~2385.
REQ-029 Backpressure: out_ready low 5 cycles in DONE -> out_valid and outputs constant, in_ready 0; out_ready high -> in_ready 1 next cycle.
REQ-030 rst pulse at iteration 5 -> outputs 0, out_valid 0 immediately; next request completes correctly with full latency.
